// File: rtl/yutorina_bus_if.sv
// CPU-stage memory access unit: SPM hits complete combinationally with zero wait states;
// other accesses run a req/grant/strobe/ready bus cycle, and busy stalls the pipe until ready or timeout.
module yutorina_bus_if #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int SPM_ADDR_W = 12,
  parameter logic [ADDR_W-SPM_ADDR_W-1:0] SPM_BASE = 18'h00200,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  req_as_,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_rw,
  input  logic [DATA_W-1:0]     req_wr_data,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  err,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [DATA_W-1:0]     spm_wr_data,
  input  logic [DATA_W-1:0]     spm_rd_data,
  output logic                  bus_req_,
  input  logic                  bus_grnt_,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_as_,
  output logic                  bus_rw,
  output logic [DATA_W-1:0]     bus_wr_data,
  input  logic [DATA_W-1:0]     bus_rd_data,
  input  logic                  bus_rdy_
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    ACCESS = 3'd2,
    WAIT   = 3'd3,
    STALL  = 3'd4
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_as_q, bus_as_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic                bus_rw_q, bus_rw_d;
  logic [DATA_W-1:0]   bus_wr_data_q, bus_wr_data_d;
  logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                hit;
  logic                busy_c;
  logic                spm_as_c;
  logic                err_c;
  logic [DATA_W-1:0]   rd_data_c;

  assign hit         = (req_addr[ADDR_W-1:SPM_ADDR_W] == SPM_BASE);
  assign spm_addr    = req_addr[SPM_ADDR_W-1:0];
  assign spm_rw      = req_rw;
  assign spm_wr_data = req_wr_data;

  always_comb begin
    state_d       = state_q;
    bus_addr_d    = bus_addr_q;
    bus_rw_d      = bus_rw_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    cnt_d         = cnt_q;
    busy_c        = 1'b0;
    spm_as_c      = 1'b1;
    err_c         = 1'b0;
    rd_data_c     = '0;

    case (state_q)
      IDLE: begin
        if (!req_as_ && !flush) begin
          if (hit) begin
            spm_as_c  = 1'b0;
            rd_data_c = req_rw ? spm_rd_data : '0;
          end else begin
            busy_c        = 1'b1;
            bus_addr_d    = req_addr;
            bus_rw_d      = req_rw;
            bus_wr_data_d = req_rw ? '0 : req_wr_data;
            state_d       = REQ;
          end
        end
      end
      REQ: begin
        busy_c = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (!bus_grnt_) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        busy_c  = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Ready is checked before the timeout so a same-cycle ready still completes cleanly.
        if (!bus_rdy_) begin
          rd_data_c = bus_rw_q ? bus_rd_data : '0;
          rd_buf_d  = bus_rw_q ? bus_rd_data : '0;
          state_d   = stall ? STALL : IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_c    = 1'b1;
          rd_buf_d = '0;
          state_d  = IDLE;
        end else begin
          busy_c = 1'b1;
          cnt_d  = cnt_q + 16'd1;
        end
      end
      STALL: begin
        rd_data_c = rd_buf_q;
        if (!stall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus handshake lines follow the state being entered, so they change right at the edge.
    bus_req_d = !((state_d == REQ) || (state_d == ACCESS) || (state_d == WAIT));
    bus_as_d  = (state_d != ACCESS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b1;
      bus_as_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_rw_q      <= 1'b1;
      bus_wr_data_q <= '0;
      rd_buf_q      <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_addr_q    <= bus_addr_d;
      bus_rw_q      <= bus_rw_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
      cnt_q         <= cnt_d;
    end
  end

  // Pipeline-facing outputs are forced quiet while reset is held, whatever the request inputs do.
  assign busy        = busy_c & ~rst;
  assign spm_as_     = spm_as_c | rst;
  assign err         = err_c & ~rst;
  assign rd_data     = rst ? '0 : rd_data_c;
  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_addr    = bus_addr_q;
  assign bus_rw      = bus_rw_q;
  assign bus_wr_data = bus_wr_data_q;

endmodule

// File: doc/yutorina_bus_if.md
Name: yutorina_bus_if

Overview:
- Parametrised memory-access unit between one CPU pipeline stage (IF or MEM) and two memory paths: the fast scratchpad (SPM) and the shared external bus.
- SPM-region accesses complete in zero wait states.
- All other accesses run a request/grant/strobe/ready bus transaction, stalling the pipeline until ready or timeout.
- One instance serves the IF stage and another serves the MEM stage in the next yutorina_cpu.

Parameters:
ADDR_W, 30, word-address width
DATA_W, 32, data width
SPM_ADDR_W, 12, SPM word-address width; SPM occupies 2^SPM_ADDR_W words
SPM_BASE, 18'h00200, required value of req_addr[ADDR_W-1:SPM_ADDR_W] for an SPM hit (width ADDR_W-SPM_ADDR_W)
TIMEOUT, 255, WAIT cycles without bus_rdy_ before abort (1..2^16-1)

Ports:
clk  in  1  clock; reset is asynchronous, active-high
rst  in  1  asynchronous active-high reset
stall  in  1  pipeline stall; holds returned data
flush  in  1  cancel pending access
req_as_  in  1  access strobe, active-low
req_addr  in  ADDR_W  word address
req_rw  in  1  1=read, 0=write
req_wr_data  in  DATA_W  write data
rd_data  out  DATA_W  read data to pipeline
busy  out  1  pipeline must stall
err  out  1  one-cycle bus-timeout pulse
spm_addr  out  SPM_ADDR_W  SPM address (req_addr low bits)
spm_as_  out  1  SPM strobe, active-low
spm_rw  out  1  SPM direction
spm_wr_data  out  DATA_W  SPM write data
spm_rd_data  in  DATA_W  SPM read data (SPM on inverted clock, valid same cycle)
bus_req_  out  1  bus request, active-low
bus_grnt_  in  1  bus grant, active-low
bus_addr  out  ADDR_W  bus address
bus_as_  out  1  bus strobe, active-low
bus_rw  out  1  bus direction
bus_wr_data  out  DATA_W  bus write data
bus_rd_data  in  DATA_W  bus read data
bus_rdy_  in  1  bus ready, active-low

Behaviour:
- Reset (async, any state): state=IDLE; bus_req_=1; bus_as_=1; bus_addr=0; bus_rw=1; bus_wr_data=0; rd_buf=0; timeout counter=0; err=0.
- Combinational outputs during reset: busy=0, spm_as_=1, rd_data=0.
- Hit decode: hit = (req_addr[ADDR_W-1:SPM_ADDR_W]==SPM_BASE). spm_addr/spm_rw/spm_wr_data always mirror the request.
- SPM path (IDLE, req_as_=0, hit, flush=0): spm_as_=0 in the same cycle; rd_data=spm_rd_data when req_rw=1, else 0. busy=0. Zero wait states; the bus is untouched.
- States: IDLE, REQ, ACCESS, WAIT, STALL.
- IDLE, external access (req_as_=0, !hit, flush=0):
  - busy=1 combinationally.
  - Register bus_addr/bus_rw/bus_wr_data (bus_wr_data=0 on reads).
  - Next state REQ.
  - With flush=1, no access starts: spm_as_=1, busy=0.
- REQ:
  - bus_req_=0, busy=1.
  - bus_grnt_=0 sampled: go to ACCESS.
  - flush=1 (takes priority over grant): go to IDLE, bus_req_=1 next cycle.
- ACCESS: bus_as_=0 for exactly this cycle; bus_req_ stays 0; busy=1; counter cleared; next state WAIT.
- WAIT: bus_as_=1, bus_req_=0; the address is held.
  - bus_rdy_=0 (normal completion):
    - This cycle: busy=0; rd_data=bus_rd_data on reads, else 0.
    - Capture rd_buf.
    - stall=1: go to STALL. Otherwise go to IDLE, with bus_req_=1 next cycle.
  - bus_rdy_=1:
    - counter increments.
    - When counter==TIMEOUT-1 without ready: err=1 for one cycle; busy=0; rd_data=0; rd_buf=0; go to IDLE.
  - flush is ignored in ACCESS/WAIT: the transaction completes and busy still drops.
- STALL:
  - busy=0; rd_data=rd_buf; bus_req_=1.
  - req_as_ is not serviced.
  - stall=0: go to IDLE.
- bus_grnt_ deassertion after ACCESS is ignored.
- Simultaneous bus_rdy_=0 and timeout in the same cycle: ready wins, err stays 0.
- A new request is accepted in the first IDLE cycle after completion; there is no back-to-back bus request inside WAIT.

Test Plan:
1. SPM read: req_addr=30'h0020_0005, req_rw=1, spm_rd_data=32'hCAFE_0001 -> spm_as_=0 same cycle, spm_addr=12'h005, rd_data=32'hCAFE_0001, busy=0, bus_req_ stays 1.
2. External read, grant after 3 cycles, ready 2 cycles after strobe:
   - Stimulus: addr 30'h0000_0100, bus_rd_data=32'h1234_5678.
   - Required: busy=1 cycles 0–5; bus_as_=0 only in the ACCESS cycle with bus_addr=30'h100, bus_rw=1; rd_data=32'h1234_5678 with busy=0 in the ready cycle; bus_req_=1 the following cycle.
3. External write 32'hDEAD_BEEF with immediate grant/ready -> bus_rw=0 and bus_wr_data=32'hDEAD_BEEF during ACCESS; busy high 3 cycles; rd_data=0.
4. Timeout with TIMEOUT=4, bus_rdy_ held 1 -> err=1 exactly one cycle, 4 cycles after ACCESS; rd_data=0; bus_req_ released; IDLE.
5. Flush and stall:
   - flush=1 while in REQ, before grant -> IDLE, bus_req_=1 next cycle, bus_as_ never asserted.
   - stall=1 at ready with data 32'h0000_00AA -> rd_data holds 32'hAA for 3 stall cycles; a new req_as_ is ignored until stall=0.
6. Reset mid-WAIT -> immediate bus_req_=1, bus_as_=1, busy=0, err=0. After release, a fresh SPM access works with zero wait.
